// File: rtl/mig_app_responder_pkg.sv
// Shared definitions for the MIG app-interface responder: command encodings,
// default bus widths and the calibration/run state type.
package mig_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int ADDR_W_DEF = 29;
  localparam int DATA_W_DEF = 256;

  typedef enum logic {
    ST_CALIB = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  function automatic logic cmd_legal(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/mig_app_responder_if.sv
// MIG 7-series user (app) interface bundle; master = user logic, slave = responder.
interface mig_app_if #(
  parameter int ADDR_W = mig_app_pkg::ADDR_W_DEF,
  parameter int DATA_W = mig_app_pkg::DATA_W_DEF
);

  // Handshakes: a command transfers on a cycle with app_en & app_rdy, a data
  // beat on a cycle with app_wdf_wren & app_wdf_rdy; the ready signals never
  // depend on their valid, and app_rd_data_valid has no backpressure.
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;
  logic [DATA_W-1:0] app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic [DATA_W/8-1:0] app_wdf_mask;
  logic              app_rdy;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
           app_wdf_mask,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
           app_wdf_mask,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end
  );

endinterface

// File: rtl/mig_app_responder_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes when full and pops when
// empty are ignored, so a push on a full FIFO is refused even alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mig_app_responder.sv
// On-chip stand-in for a MIG 7-series DDR3 controller: in-order command
// execution against a small byte-maskable array. Define MIG_RESP_THROTTLE_EN
// to add periodic backpressure on app_rdy / app_wdf_rdy.
module mig_app_responder
  import mig_app_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEPTH_LOG2      = 6,
  parameter int FIFO_DEPTH      = 4,
  parameter int RD_LATENCY      = 4,
  parameter int CALIB_CYCLES    = 16,
  parameter int THROTTLE_PERIOD = 7
) (
  input  logic   ui_clk,
  input  logic   ui_clk_sync_rst,
  mig_app_if.slave app,
  output logic   init_calib_complete,
  output logic   cmd_err,
  output state_t dbg_state
);

  localparam int DEPTH     = 1 << DEPTH_LOG2;
  localparam int MASK_W    = DATA_W / 8;
  localparam int CMD_ENT_W = 3 + DEPTH_LOG2;
  localparam int DAT_ENT_W = MASK_W + DATA_W;
  localparam int CNT_W     = $clog2(CALIB_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] calib_cnt_q, calib_cnt_d;
  logic             cmd_err_q, cmd_err_d;
  logic             thr_block_cmd, thr_block_wdf;

  logic                 cmd_full, cmd_empty, dat_full, dat_empty;
  logic [CMD_ENT_W-1:0] cmd_dout;
  logic [DAT_ENT_W-1:0] dat_dout;
  logic                 cmd_accept, cmd_push, dat_push;
  logic                 exec_rd, exec_wr;
  logic [2:0]           head_cmd;
  logic [DEPTH_LOG2-1:0] head_idx;
  logic [MASK_W-1:0]    wr_mask;
  logic [DATA_W-1:0]    wr_data;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [RD_LATENCY-1:0] rd_vld_q, rd_vld_d;
  logic [DATA_W-1:0]     rd_dat_q [RD_LATENCY];
  logic [DATA_W-1:0]     rd_dat_d [RD_LATENCY];

  logic unused_in;
  assign unused_in = ^{app.app_wdf_end, app.app_addr};

  // ---- FSM: state register ----
  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      state_q     <= ST_CALIB;
      calib_cnt_q <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      calib_cnt_q <= calib_cnt_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d     = state_q;
    calib_cnt_d = calib_cnt_q;
    if (state_q == ST_CALIB) begin
      calib_cnt_d = calib_cnt_q + CNT_W'(1);
      if (calib_cnt_q == CNT_W'(CALIB_CYCLES - 1)) state_d = ST_RUN;
    end
  end

  // ---- FSM: outputs ----
  always_comb begin
    init_calib_complete = (state_q == ST_RUN);
    app.app_rdy         = (state_q == ST_RUN) & ~cmd_full & ~thr_block_cmd;
    app.app_wdf_rdy     = (state_q == ST_RUN) & ~dat_full & ~thr_block_wdf;
    cmd_err             = cmd_err_q;
    dbg_state           = state_q;
  end

`ifdef MIG_RESP_THROTTLE_EN
  localparam int THR_W = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  logic [THR_W-1:0] thr_cnt_q, thr_cnt_d;

  always_comb begin
    thr_cnt_d = (thr_cnt_q == THR_W'(THROTTLE_PERIOD - 1)) ? '0 : thr_cnt_q + THR_W'(1);
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) thr_cnt_q <= '0;
    else                 thr_cnt_q <= thr_cnt_d;
  end

  assign thr_block_cmd = (thr_cnt_q == '0);
  assign thr_block_wdf = (thr_cnt_q == THR_W'(THROTTLE_PERIOD / 2));
`else
  localparam int unused_thr_period = THROTTLE_PERIOD;
  assign thr_block_cmd = 1'b0;
  assign thr_block_wdf = 1'b0;
`endif

  // Illegal commands are accepted but never enter the FIFO, so they cannot stall.
  assign cmd_accept = app.app_en & app.app_rdy;
  assign cmd_push   = cmd_accept & cmd_legal(app.app_cmd);
  assign dat_push   = app.app_wdf_wren & app.app_wdf_rdy;
  assign cmd_err_d  = cmd_err_q | (cmd_accept & ~cmd_legal(app.app_cmd));

  sync_fifo #(.WIDTH(CMD_ENT_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (cmd_push),
    .din   ({app.app_cmd, app.app_addr[3 +: DEPTH_LOG2]}),
    .pop   (exec_rd | exec_wr),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  sync_fifo #(.WIDTH(DAT_ENT_W), .DEPTH(FIFO_DEPTH)) u_dat_fifo (
    .clk   (ui_clk),
    .rst   (ui_clk_sync_rst),
    .push  (dat_push),
    .din   ({app.app_wdf_mask, app.app_wdf_data}),
    .pop   (exec_wr),
    .dout  (dat_dout),
    .full  (dat_full),
    .empty (dat_empty)
  );

  assign head_cmd = cmd_dout[CMD_ENT_W-1 -: 3];
  assign head_idx = cmd_dout[DEPTH_LOG2-1:0];
  assign wr_mask  = dat_dout[DAT_ENT_W-1 -: MASK_W];
  assign wr_data  = dat_dout[DATA_W-1:0];

  // A write at the head without data blocks everything behind it.
  assign exec_rd = ~cmd_empty & (head_cmd == CMD_READ);
  assign exec_wr = ~cmd_empty & (head_cmd == CMD_WRITE) & ~dat_empty;

  always_ff @(posedge ui_clk) begin
    if (exec_wr) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wr_mask[b]) mem[head_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    rd_vld_d = '0;
    for (int i = 0; i < RD_LATENCY; i++) rd_dat_d[i] = '0;
    for (int i = RD_LATENCY - 1; i > 0; i--) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      rd_dat_d[i] = rd_dat_q[i-1];
    end
    rd_vld_d[0] = exec_rd;
    rd_dat_d[0] = exec_rd ? mem[head_idx] : '0;
  end

  always_ff @(posedge ui_clk or posedge ui_clk_sync_rst) begin
    if (ui_clk_sync_rst) begin
      rd_vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= '0;
    end else begin
      rd_vld_q <= rd_vld_d;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat_q[i] <= rd_dat_d[i];
    end
  end

  assign app.app_rd_data       = rd_dat_q[RD_LATENCY-1];
  assign app.app_rd_data_valid = rd_vld_q[RD_LATENCY-1];
  assign app.app_rd_data_end   = rd_vld_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder: reset/calibration, sequential
// write/read, byte masking, write-data stall, illegal command and mid-run reset.
module tb_mig_app_responder;
  import mig_app_pkg::*;

  localparam int AW = 29;
  localparam int DW = 256;
  localparam int MW = DW / 8;

  // ---- clock / reset ----
  logic   ui_clk = 1'b0;
  logic   ui_clk_sync_rst = 1'b1;
  logic   init_calib_complete, cmd_err;
  state_t dbg_state;

  always #5 ui_clk = ~ui_clk;

  int cyc = 0;
  always @(posedge ui_clk) cyc <= cyc + 1;

  mig_app_if #(.ADDR_W(AW), .DATA_W(DW)) app_if ();

  mig_app_responder dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .app                 (app_if),
    .init_calib_complete (init_calib_complete),
    .cmd_err             (cmd_err),
    .dbg_state           (dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---- scoreboard ----
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_d;
  int vld_cnt = 0;
  int first_vld = -1;
  int last_vld = -1;

  always @(negedge ui_clk) begin
    if (app_if.app_rd_data_valid === 1'b1 || app_if.app_rd_data_end === 1'b1) begin
      vectors++;
      if (app_if.app_rd_data_end !== app_if.app_rd_data_valid) begin
        miscompares++;
        $display("FAIL rd_data_end: got %b, required %b", app_if.app_rd_data_end, app_if.app_rd_data_valid);
      end
    end
    if (app_if.app_rd_data_valid === 1'b1) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_unexpected: got valid with data %h, required no valid", app_if.app_rd_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (app_if.app_rd_data !== exp_d) begin
          miscompares++;
          $display("FAIL rd_data: got %h, required %h", app_if.app_rd_data, exp_d);
        end
      end
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [AW-1:0] addr, output int acc_cyc);
    int n;
    n = 0;
    app_if.app_en   = 1'b1;
    app_if.app_cmd  = cmd;
    app_if.app_addr = addr;
    while (app_if.app_rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL cmd_accept_timeout: app_rdy=%b after %0d cycles, required 1", app_if.app_rdy, n);
    end
    acc_cyc = cyc;
    tick();
    app_if.app_en = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] data, input logic [MW-1:0] mask);
    int n;
    n = 0;
    app_if.app_wdf_wren = 1'b1;
    app_if.app_wdf_end  = 1'b1;
    app_if.app_wdf_data = data;
    app_if.app_wdf_mask = mask;
    while (app_if.app_wdf_rdy !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL wdf_accept_timeout: app_wdf_rdy=%b after %0d cycles, required 1", app_if.app_wdf_rdy, n);
    end
    tick();
    app_if.app_wdf_wren = 1'b0;
    app_if.app_wdf_end  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (8) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    logic exp_b;
    ui_clk_sync_rst = 1'b1;
    repeat (3) tick();
    vectors += 6;
    if (app_if.app_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_app_rdy: got %b, required 0", app_if.app_rdy); end
    if (app_if.app_wdf_rdy !== 1'b0) begin miscompares++; $display("FAIL rst_wdf_rdy: got %b, required 0", app_if.app_wdf_rdy); end
    if (app_if.app_rd_data_valid !== 1'b0) begin miscompares++; $display("FAIL rst_rd_valid: got %b, required 0", app_if.app_rd_data_valid); end
    if (app_if.app_rd_data !== '0) begin miscompares++; $display("FAIL rst_rd_data: got %h, required 0", app_if.app_rd_data); end
    if (init_calib_complete !== 1'b0) begin miscompares++; $display("FAIL rst_calib: got %b, required 0", init_calib_complete); end
    if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL rst_cmd_err: got %b, required 0", cmd_err); end
    ui_clk_sync_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_b = (i >= 16);
      vectors += 3;
      if (init_calib_complete !== exp_b) begin miscompares++; $display("FAIL calib_cycle%0d: got %b, required %b", i, init_calib_complete, exp_b); end
      if (app_if.app_rdy !== exp_b) begin miscompares++; $display("FAIL calib_rdy_cycle%0d: got %b, required %b", i, app_if.app_rdy, exp_b); end
      if (app_if.app_wdf_rdy !== exp_b) begin miscompares++; $display("FAIL calib_wdf_rdy_cycle%0d: got %b, required %b", i, app_if.app_wdf_rdy, exp_b); end
    end
    vectors++;
    if (dbg_state !== ST_RUN) begin miscompares++; $display("FAIL calib_state: got %0d, required %0d", dbg_state, ST_RUN); end
  endtask

  task automatic test_seq_write_read();
    int acc, acc0, v0;
    acc0 = 0;
    for (int i = 0; i < 20; i++) begin
      send_cmd(CMD_WRITE, AW'(i * 8), acc);
      send_data(DW'(i * 2), '0);
    end
    first_vld = -1;
    v0 = vld_cnt;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(DW'(i * 2));
      send_cmd(CMD_READ, AW'(i * 8), acc);
      if (i == 0) acc0 = acc;
    end
    drain("seq");
    vectors += 3;
    if (vld_cnt - v0 != 20) begin miscompares++; $display("FAIL seq_valid_count: got %0d, required 20", vld_cnt - v0); end
    if (first_vld != acc0 + 5) begin miscompares++; $display("FAIL seq_first_latency: got %0d, required 5", first_vld - acc0); end
    if (last_vld - first_vld != 19) begin miscompares++; $display("FAIL seq_b2b_span: got %0d, required 19", last_vld - first_vld); end
  endtask

  task automatic test_mask();
    int acc;
    send_cmd(CMD_WRITE, '0, acc);
    send_data('1, '0);
    send_cmd(CMD_WRITE, '0, acc);
    send_data('0, 32'hFFFF_FFFE);
    exp_q.push_back({{31{8'hFF}}, 8'h00});
    send_cmd(CMD_READ, '0, acc);
    drain("mask");
  endtask

  task automatic test_stall();
    int acc;
    logic [DW-1:0] d [4];
    for (int k = 0; k < 4; k++) d[k] = {8{32'hC0DE_0000 + 32'(k)}};
    for (int k = 0; k < 4; k++) send_cmd(CMD_WRITE, AW'(k * 8), acc);
    repeat (3) tick();
    vectors += 2;
    if (app_if.app_rdy !== 1'b0) begin miscompares++; $display("FAIL stall_app_rdy: got %b, required 0", app_if.app_rdy); end
    if (app_if.app_wdf_rdy !== 1'b1) begin miscompares++; $display("FAIL stall_wdf_rdy: got %b, required 1", app_if.app_wdf_rdy); end
    for (int k = 0; k < 4; k++) send_data(d[k], '0);
    exp_q.push_back(d[0]);
    send_cmd(CMD_READ, AW'(512), acc);
    for (int k = 1; k < 4; k++) begin
      exp_q.push_back(d[k]);
      send_cmd(CMD_READ, AW'(k * 8), acc);
    end
    drain("stall");
  endtask

  task automatic test_illegal();
    int acc, v0;
    vectors++;
    if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL illegal_pre_err: got %b, required 0", cmd_err); end
    v0 = vld_cnt;
    send_cmd(3'b010, '0, acc);
    send_data({8{32'hDEAD_BEEF}}, '0);
    repeat (10) tick();
    vectors += 2;
    if (cmd_err !== 1'b1) begin miscompares++; $display("FAIL illegal_err: got %b, required 1", cmd_err); end
    if (vld_cnt != v0) begin miscompares++; $display("FAIL illegal_no_valid: got %0d valids, required 0", vld_cnt - v0); end
    exp_q.push_back({8{32'hC0DE_0000}});
    send_cmd(CMD_READ, '0, acc);
    drain("illegal");
  endtask

  task automatic test_reset_mid();
    int acc, v0;
    v0 = vld_cnt;
    send_cmd(CMD_READ, '0, acc);
    send_cmd(CMD_READ, AW'(8), acc);
    ui_clk_sync_rst = 1'b1;
    tick();
    vectors += 3;
    if (cmd_err !== 1'b0) begin miscompares++; $display("FAIL midrst_cmd_err: got %b, required 0", cmd_err); end
    if (init_calib_complete !== 1'b0) begin miscompares++; $display("FAIL midrst_calib: got %b, required 0", init_calib_complete); end
    if (app_if.app_rdy !== 1'b0) begin miscompares++; $display("FAIL midrst_rdy: got %b, required 0", app_if.app_rdy); end
    repeat (3) tick();
    ui_clk_sync_rst = 1'b0;
    repeat (20) tick();
    vectors += 2;
    if (vld_cnt != v0) begin miscompares++; $display("FAIL midrst_no_valid: got %0d valids, required 0", vld_cnt - v0); end
    if (init_calib_complete !== 1'b1) begin miscompares++; $display("FAIL midrst_recal: got %b, required 1", init_calib_complete); end
    // A leftover data beat from before reset would overwrite this one.
    send_cmd(CMD_WRITE, '0, acc);
    send_data({8{32'h1234_5678}}, '0);
    exp_q.push_back({8{32'h1234_5678}});
    send_cmd(CMD_READ, '0, acc);
    drain("midrst");
  endtask

`ifdef MIG_RESP_THROTTLE_EN
  task automatic test_throttle();
    int lows;
    lows = 0;
    app_if.app_en   = 1'b1;
    app_if.app_cmd  = CMD_READ;
    app_if.app_addr = AW'(8);
    for (int i = 0; i < 28; i++) begin
      if (app_if.app_rdy === 1'b1) exp_q.push_back({8{32'hC0DE_0001}});
      else lows++;
      tick();
    end
    app_if.app_en = 1'b0;
    vectors++;
    if (lows != 4) begin miscompares++; $display("FAIL throttle_low_cycles: got %0d, required 4", lows); end
    drain("throttle");
  endtask
`endif

  initial begin
    app_if.app_en       = 1'b0;
    app_if.app_cmd      = '0;
    app_if.app_addr     = '0;
    app_if.app_wdf_data = '0;
    app_if.app_wdf_wren = 1'b0;
    app_if.app_wdf_end  = 1'b0;
    app_if.app_wdf_mask = '0;

    test_reset();
    test_seq_write_read();
    test_mask();
    test_stall();
    test_illegal();
    test_reset_mid();
`ifdef MIG_RESP_THROTTLE_EN
    test_throttle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
